// File: rtl/alu_bcd_display.sv
// Registered ALU with sequential double-dabble BCD conversion and multiplexed 7-seg scan.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero one.
module alu_bcd_display #(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1024
) (
  input  logic              CLK_in,
  input  logic              RST_in,
  input  logic [WIDTH-1:0]  Num_A_in,
  input  logic [WIDTH-1:0]  Num_B_in,
  input  logic [1:0]        Sel_A_in,
  input  logic              Start_in,
  input  logic              Disp_en_in,
  output logic [6:0]        Seg_out,
  output logic [DIGITS-1:0] Dig_en_out,
  output logic              Neg_out,
  output logic              Ovf_out,
  output logic              Busy_out,
  output logic              Done_out
);

  localparam int RW  = 2 * WIDTH;
  localparam int NBR = (RW + 2) / 3;
  localparam int NB  = (NBR > DIGITS) ? NBR : DIGITS;
  localparam int SW  = 4 * NB + RW;
  localparam int CW  = $clog2(RW + 1);
  localparam int RCW = $clog2(REFRESH_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_CONV, S_LOAD
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic                sign_q, sign_d;
  logic [SW-1:0]       sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [RCW-1:0]      ref_q, ref_d;
  logic [IW-1:0]       idx_q, idx_d;

  logic                accept;
  logic [RW-1:0]       mag;
  logic [SW-1:0]       adj;
  logic [3:0]          nib;
  logic                blank;
  logic                zero_above;
  logic [6:0]          seg;

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
    end
  end

  // LOAD also accepts a start so a held strobe restarts every RW+2 cycles
  assign accept = Start_in && (state_q == S_IDLE || state_q == S_LOAD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (Start_in) state_d = S_CALC;
      S_CALC: state_d = S_CONV;
      S_CONV: if (cnt_q == CW'(RW - 1)) state_d = S_LOAD;
      S_LOAD: state_d = Start_in ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    sign_d = sign_q;
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    mag    = '0;
    adj    = sr_q;
    if (accept) begin
      a_d  = Num_A_in;
      b_d  = Num_B_in;
      op_d = Sel_A_in;
    end
    case (op_q)
      2'b00: mag = RW'(a_q) + RW'(b_q);
      2'b01: mag = (a_q >= b_q) ? RW'(a_q - b_q) : RW'(b_q - a_q);
      2'b10: mag = RW'(a_q) * RW'(b_q);
      default: mag = RW'(a_q & b_q);
    endcase
    if (state_q == S_CALC) begin
      sign_d = (op_q == 2'b01) && (a_q < b_q);
      sr_d   = {{(4*NB){1'b0}}, mag};
      cnt_d  = '0;
    end
    if (state_q == S_CONV) begin
      for (int i = 0; i < NB; i++)
        if (sr_q[RW+4*i +: 4] >= 4'd5)
          adj[RW+4*i +: 4] = sr_q[RW+4*i +: 4] + 4'd3;
      sr_d  = adj << 1;
      cnt_d = cnt_q + CW'(1);
    end
    if (state_q == S_LOAD) begin
      disp_d = sr_q[RW +: 4*DIGITS];
      neg_d  = sign_q;
      ovf_d  = 1'b0;
      for (int i = DIGITS; i < NB; i++)
        ovf_d = ovf_d | (|sr_q[RW+4*i +: 4]);
      done_d = 1'b1;
    end
  end

  always_comb begin
    ref_d = ref_q + RCW'(1);
    idx_d = idx_q;
    if (ref_q == RCW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    nib        = 4'd0;
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        nib = disp_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = zero_above && (i != 0);
`else
        blank = 1'b0;
`endif
      end
    end
    case (nib)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    if (ovf_q) seg = 7'h40;
    else if (blank) seg = 7'h00;
    Seg_out = Disp_en_in ? seg : 7'h00;
    for (int i = 0; i < DIGITS; i++)
      Dig_en_out[i] = Disp_en_in && (idx_q == IW'(i));
  end

  assign Neg_out  = neg_q;
  assign Ovf_out  = ovf_q;
  assign Busy_out = (state_q != S_IDLE);
  assign Done_out = done_q;

endmodule

// File: tb/tb_alu_bcd_display.sv
// Directed bench for alu_bcd_display: DIGITS=3 main instance plus a DIGITS=2 twin for overflow.
module tb_alu_bcd_display;

  logic       clk = 1'b0;
  logic       rst, start, disp_en;
  logic [3:0] a, b;
  logic [1:0] sel;
  logic [6:0] seg, seg2;
  logic [2:0] dig;
  logic [1:0] dig2;
  logic       neg, ovf, busy, done;
  logic       neg2, ovf2, busy2, done2;
  logic [6:0] got1 [3];
  logic [6:0] got2 [2];
  int         checks = 0;
  int         errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] BLK = 7'h00;
`else
  localparam logic [6:0] BLK = 7'h3F;
`endif

  always #5 clk = ~clk;

  alu_bcd_display #(.WIDTH(4), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .CLK_in(clk), .RST_in(rst), .Num_A_in(a), .Num_B_in(b),
    .Sel_A_in(sel), .Start_in(start), .Disp_en_in(disp_en),
    .Seg_out(seg), .Dig_en_out(dig), .Neg_out(neg), .Ovf_out(ovf),
    .Busy_out(busy), .Done_out(done)
  );

  alu_bcd_display #(.WIDTH(4), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
    .CLK_in(clk), .RST_in(rst), .Num_A_in(a), .Num_B_in(b),
    .Sel_A_in(sel), .Start_in(start), .Disp_en_in(disp_en),
    .Seg_out(seg2), .Dig_en_out(dig2), .Neg_out(neg2), .Ovf_out(ovf2),
    .Busy_out(busy2), .Done_out(done2)
  );

  task automatic start_op(input logic [3:0] aa, input logic [3:0] bb,
                          input logic [1:0] op);
    @(negedge clk);
    a = aa; b = bb; sel = op; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got %b exp 1", done);
    end
  endtask

  task automatic read_digits();
    logic [2:0] seen1 = '0;
    logic [1:0] seen2 = '0;
    for (int n = 0; n < 40 && !(&seen1 && &seen2); n++) begin
      for (int i = 0; i < 3; i++)
        if (dig[i]) begin got1[i] = seg; seen1[i] = 1'b1; end
      for (int i = 0; i < 2; i++)
        if (dig2[i]) begin got2[i] = seg2; seen2[i] = 1'b1; end
      @(negedge clk);
    end
    checks++;
    if (!(&seen1 && &seen2)) begin
      errors++;
      $display("FAIL scan_timeout got %b/%b exp all seen", seen1, seen2);
    end
  endtask

  task automatic check_digits(input string nm, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2);
    read_digits();
    checks++;
    if (got1[0] !== e0 || got1[1] !== e1 || got1[2] !== e2) begin
      errors++;
      $display("FAIL %s_digits got %h %h %h exp %h %h %h", nm,
               got1[2], got1[1], got1[0], e2, e1, e0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (seg !== 7'h3F || dig !== 3'b001) begin
      errors++;
      $display("FAIL reset_disp got %h %b exp 3f 001", seg, dig);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || neg !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b%b exp 0000", busy, done, neg, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [2:0] exp_dig;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 21; k++) begin
      disp_en = !(k >= 13 && k <= 17);
      #1;
      exp_dig = disp_en ? 3'(1 << ((k / 4) % 3)) : 3'b000;
      checks++;
      if (dig !== exp_dig) begin
        errors++;
        $display("FAIL scan_k%0d got %b exp %b", k, dig, exp_dig);
      end
      if (!disp_en) begin
        checks++;
        if (seg !== 7'h00) begin
          errors++;
          $display("FAIL scan_blank_k%0d got %h exp 00", k, seg);
        end
      end
      @(negedge clk);
    end
    disp_en = 1'b1;
  endtask

  task automatic test_add();
    int  cyc = 0;
    bit  early = 0;
    start_op(4'd9, 4'd7, 2'b00);
    while (busy && cyc < 40) begin
      cyc++;
      if (done) early = 1;
      @(negedge clk);
    end
    checks++;
    if (cyc != 10 || early) begin
      errors++;
      $display("FAIL add_busy got %0d early %0d exp 10 early 0", cyc, early);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL add_done got %b exp 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL add_done_pulse got %b exp 0", done);
    end
    check_digits("add", 7'h7D, 7'h06, BLK);
    checks++;
    if (neg !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_flags got %b%b exp 00", neg, ovf);
    end
  endtask

  task automatic test_sub();
    start_op(4'd3, 4'd12, 2'b01);
    repeat (4) @(negedge clk);
    checks++;
    if (neg !== 1'b0 || got1[0] !== 7'h7D) begin
      errors++;
      $display("FAIL sub_hold got neg %b exp 0", neg);
    end
    wait_done();
    check_digits("sub", 7'h6F, BLK, BLK);
    checks++;
    if (neg !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_flags got %b%b exp 10", neg, ovf);
    end
  endtask

  task automatic test_mul();
    start_op(4'd15, 4'd15, 2'b10);
    wait_done();
    check_digits("mul", 7'h6D, 7'h5B, 7'h5B);
    checks++;
    if (ovf !== 1'b0 || neg !== 1'b0) begin
      errors++;
      $display("FAIL mul_flags got %b%b exp 00", neg, ovf);
    end
    checks++;
    if (ovf2 !== 1'b1 || neg2 !== 1'b0) begin
      errors++;
      $display("FAIL mul2_flags got %b%b exp 01", neg2, ovf2);
    end
    checks++;
    if (got2[0] !== 7'h40 || got2[1] !== 7'h40) begin
      errors++;
      $display("FAIL mul2_dash got %h %h exp 40 40", got2[1], got2[0]);
    end
  endtask

  task automatic test_and();
    start_op(4'd12, 4'd10, 2'b11);
    wait_done();
    check_digits("and", 7'h7F, BLK, BLK);
    checks++;
    if (neg !== 1'b0 || ovf2 !== 1'b0 || got2[0] !== 7'h7F) begin
      errors++;
      $display("FAIL and_flags got %b %b %h exp 0 0 7f", neg, ovf2, got2[0]);
    end
  endtask

  task automatic test_abort();
    bit seen_done = 0;
    start_op(4'd9, 4'd9, 2'b10);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b%b exp 00", busy, done);
    end
    for (int n = 0; n < 15; n++) begin
      if (done) seen_done = 1;
      @(negedge clk);
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL abort_nodone got 1 exp 0");
    end
    check_digits("abort", 7'h3F, BLK, BLK);
    checks++;
    if (neg !== 1'b0 || ovf !== 1'b0 || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags got %b%b%b exp 000", neg, ovf, ovf2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; disp_en = 1'b1;
    a = '0; b = '0; sel = '0;
    test_reset();
    test_scan();
    test_add();
    test_sub();
    test_mul();
    test_and();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
